// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// id_stage_pipe : decode stage (register file, decoder, imm gen, load-use hazard)
// Revision      : 1.0
// ============================================================================
module id_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [XLEN-1:0]       if_pc_i,
  input  logic [31:0]           if_inst_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  ex_ld_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_ld_rd_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [XLEN-1:0]       id_pc_o,
  output logic [XLEN-1:0]       id_rs1_o,
  output logic [XLEN-1:0]       id_rs2_o,
  output logic [REG_ADDR_W-1:0] id_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] id_rs2_addr_o,
  output logic [REG_ADDR_W-1:0] id_rd_o,
  output logic [XLEN-1:0]       id_imm_o,
  output logic [2:0]            id_funct3_o,
  output logic                  id_funct7b5_o,
  output logic                  id_alu_src_o,
  output logic [1:0]            id_alu_op_o,
  output logic                  id_mem_read_o,
  output logic                  id_mem_write_o,
  output logic                  id_reg_write_o,
  output logic                  id_is_branch_o,
  output logic                  id_is_jump_o,
  output logic [1:0]            id_wb_sel_o,
  output logic                  id_illegal_o
);
  localparam int c_NREGS = 1 << REG_ADDR_W;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] c_IMM_NONE = 3'd0;
  localparam logic [2:0] c_IMM_I    = 3'd1;
  localparam logic [2:0] c_IMM_S    = 3'd2;
  localparam logic [2:0] c_IMM_B    = 3'd3;
  localparam logic [2:0] c_IMM_U    = 3'd4;
  localparam logic [2:0] c_IMM_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1;
    logic [XLEN-1:0]       rs2;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  is_branch;
    logic                  is_jump;
    logic [1:0]            wb_sel;
    logic                  illegal;
  } slot_t;

  logic [XLEN-1:0]       regs_q [c_NREGS];
  slot_t                 slot_d, slot_q, dec;
  logic                  valid_d, valid_q;
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr;
  logic                  use_rs1, use_rs2, hazard, slot_free, wb_wr;
  logic                  alu_src, mem_read, mem_write, reg_write, is_branch, is_jump, illegal;
  logic [1:0]            alu_op, wb_sel;
  logic [2:0]            imm_sel;
  logic [31:0]           imm32;
  logic [XLEN-1:0]       imm_ext, rs1_val, rs2_val;

  assign opcode   = if_inst_i[6:0];
  assign rs1_addr = REG_ADDR_W'(if_inst_i[19:15]);
  assign rs2_addr = REG_ADDR_W'(if_inst_i[24:20]);
  assign rd_addr  = REG_ADDR_W'(if_inst_i[11:7]);
  assign wb_wr    = wb_we_i && (wb_addr_i != '0);

  always_comb begin
    alu_src = 1'b0; alu_op = 2'b00; mem_read = 1'b0; mem_write = 1'b0;
    reg_write = 1'b0; is_branch = 1'b0; is_jump = 1'b0; wb_sel = 2'b00;
    illegal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; imm_sel = c_IMM_NONE;
    case (opcode)
      c_OPC_OP:     begin reg_write = 1'b1; alu_op = 2'b10; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      c_OPC_OP_IMM: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; use_rs1 = 1'b1; imm_sel = c_IMM_I; end
      c_OPC_LOAD:   begin reg_write = 1'b1; alu_src = 1'b1; mem_read = 1'b1; wb_sel = 2'b01; use_rs1 = 1'b1; imm_sel = c_IMM_I; end
      c_OPC_STORE:  begin alu_src = 1'b1; mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = c_IMM_S; end
      c_OPC_BRANCH: begin is_branch = 1'b1; alu_op = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = c_IMM_B; end
      c_OPC_JAL:    begin reg_write = 1'b1; is_jump = 1'b1; wb_sel = 2'b10; imm_sel = c_IMM_J; end
      c_OPC_JALR:   begin reg_write = 1'b1; alu_src = 1'b1; is_jump = 1'b1; wb_sel = 2'b10; use_rs1 = 1'b1; imm_sel = c_IMM_I; end
      c_OPC_LUI:    begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b11; imm_sel = c_IMM_U; end
      c_OPC_AUIPC:  begin reg_write = 1'b1; alu_src = 1'b1; imm_sel = c_IMM_U; end
      default:      illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      c_IMM_I: imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
      c_IMM_S: imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
      c_IMM_B: imm32 = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7], if_inst_i[30:25], if_inst_i[11:8], 1'b0};
      c_IMM_U: imm32 = {if_inst_i[31:12], 12'b0};
      c_IMM_J: imm32 = {{11{if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12], if_inst_i[20], if_inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_imm_narrow
      assign imm_ext = imm32;
    end
  endgenerate

  // x0 override is applied last so a bypass can never make it nonzero
  always_comb begin
    rs1_val = regs_q[rs1_addr];
    rs2_val = regs_q[rs2_addr];
    if (BYPASS_EN && wb_wr && (wb_addr_i == rs1_addr)) rs1_val = wb_data_i;
    if (BYPASS_EN && wb_wr && (wb_addr_i == rs2_addr)) rs2_val = wb_data_i;
    if (rs1_addr == '0) rs1_val = '0;
    if (rs2_addr == '0) rs2_val = '0;
  end

  always_comb begin
    dec           = '0;
    dec.pc        = if_pc_i;
    dec.rs1       = rs1_val;
    dec.rs2       = rs2_val;
    dec.rs1_addr  = rs1_addr;
    dec.rs2_addr  = rs2_addr;
    dec.rd        = rd_addr;
    dec.imm       = imm_ext;
    dec.funct3    = if_inst_i[14:12];
    dec.funct7b5  = if_inst_i[30];
    dec.alu_src   = alu_src;
    dec.alu_op    = alu_op;
    dec.mem_read  = mem_read;
    dec.mem_write = mem_write;
    dec.reg_write = reg_write;
    dec.is_branch = is_branch;
    dec.is_jump   = is_jump;
    dec.wb_sel    = wb_sel;
    dec.illegal   = illegal;
  end

  assign hazard = if_valid_i && ex_ld_valid_i && (ex_ld_rd_i != '0) &&
                  ((use_rs1 && (rs1_addr == ex_ld_rd_i)) || (use_rs2 && (rs2_addr == ex_ld_rd_i)));
  assign slot_free  = !valid_q || id_ready_i;
  assign if_ready_o = flush_i || (slot_free && !hazard);

  // A held slot keeps its operands current with write-back so EX never sees stale data
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (slot_free) begin
      valid_d = if_valid_i && !hazard;
      if (if_valid_i && !hazard) slot_d = dec;
    end else begin
      if (wb_wr && (wb_addr_i == slot_q.rs1_addr)) slot_d.rs1 = wb_data_i;
      if (wb_wr && (wb_addr_i == slot_q.rs2_addr)) slot_d.rs2 = wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < c_NREGS; i++) regs_q[i] <= '0;
    end else if (wb_wr) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign id_valid_o     = valid_q;
  assign id_pc_o        = slot_q.pc;
  assign id_rs1_o       = slot_q.rs1;
  assign id_rs2_o       = slot_q.rs2;
  assign id_rs1_addr_o  = slot_q.rs1_addr;
  assign id_rs2_addr_o  = slot_q.rs2_addr;
  assign id_rd_o        = slot_q.rd;
  assign id_imm_o       = slot_q.imm;
  assign id_funct3_o    = slot_q.funct3;
  assign id_funct7b5_o  = slot_q.funct7b5;
  assign id_alu_src_o   = slot_q.alu_src;
  assign id_alu_op_o    = slot_q.alu_op;
  assign id_mem_read_o  = slot_q.mem_read;
  assign id_mem_write_o = slot_q.mem_write;
  assign id_reg_write_o = slot_q.reg_write;
  assign id_is_branch_o = slot_q.is_branch;
  assign id_is_jump_o   = slot_q.is_jump;
  assign id_wb_sel_o    = slot_q.wb_sel;
  assign id_illegal_o   = slot_q.illegal;
endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// tb_id_stage_pipe : directed and random check of id_stage_pipe (bypass on/off)
// Revision         : 1.0
// ============================================================================
module tb_id_stage_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, flush_i, if_valid_i, wb_we_i, ex_ld_valid_i, id_ready_i;
  logic [31:0] if_pc_i, if_inst_i, wb_data_i;
  logic [4:0]  wb_addr_i, ex_ld_rd_i;

  logic        if_ready_o, id_valid_o, id_funct7b5_o, id_alu_src_o, id_mem_read_o, id_mem_write_o;
  logic        id_reg_write_o, id_is_branch_o, id_is_jump_o, id_illegal_o;
  logic [31:0] id_pc_o, id_rs1_o, id_rs2_o, id_imm_o;
  logic [4:0]  id_rs1_addr_o, id_rs2_addr_o, id_rd_o;
  logic [2:0]  id_funct3_o;
  logic [1:0]  id_alu_op_o, id_wb_sel_o;

  logic        n_if_ready, n_valid, n_f7, n_src, n_mr, n_mw, n_rw, n_br, n_jp, n_ill;
  logic [31:0] n_pc, n_rs1, n_rs2, n_imm;
  logic [4:0]  n_a1, n_a2, n_rd;
  logic [2:0]  n_f3;
  logic [1:0]  n_aop, n_wb;

  id_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .BYPASS_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .ex_ld_valid_i(ex_ld_valid_i), .ex_ld_rd_i(ex_ld_rd_i), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o), .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o), .id_rs1_addr_o(id_rs1_addr_o),
    .id_rs2_addr_o(id_rs2_addr_o), .id_rd_o(id_rd_o), .id_imm_o(id_imm_o), .id_funct3_o(id_funct3_o),
    .id_funct7b5_o(id_funct7b5_o), .id_alu_src_o(id_alu_src_o), .id_alu_op_o(id_alu_op_o),
    .id_mem_read_o(id_mem_read_o), .id_mem_write_o(id_mem_write_o), .id_reg_write_o(id_reg_write_o),
    .id_is_branch_o(id_is_branch_o), .id_is_jump_o(id_is_jump_o), .id_wb_sel_o(id_wb_sel_o),
    .id_illegal_o(id_illegal_o)
  );

  id_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .BYPASS_EN(1'b0)) dut_nb (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .if_valid_i(if_valid_i), .if_ready_o(n_if_ready),
    .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .ex_ld_valid_i(ex_ld_valid_i), .ex_ld_rd_i(ex_ld_rd_i), .id_valid_o(n_valid), .id_ready_i(id_ready_i),
    .id_pc_o(n_pc), .id_rs1_o(n_rs1), .id_rs2_o(n_rs2), .id_rs1_addr_o(n_a1), .id_rs2_addr_o(n_a2),
    .id_rd_o(n_rd), .id_imm_o(n_imm), .id_funct3_o(n_f3), .id_funct7b5_o(n_f7), .id_alu_src_o(n_src),
    .id_alu_op_o(n_aop), .id_mem_read_o(n_mr), .id_mem_write_o(n_mw), .id_reg_write_o(n_rw),
    .id_is_branch_o(n_br), .id_is_jump_o(n_jp), .id_wb_sel_o(n_wb), .id_illegal_o(n_ill)
  );

  typedef struct packed {
    logic [31:0] pc, rs1, rs2;
    logic [4:0]  a1, a2, rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7, src;
    logic [1:0]  aop;
    logic        mr, mw, rw, br, jp;
    logic [1:0]  wb;
    logic        ill;
  } slot_t;

  typedef struct packed {
    logic       legal, u1, u2, src;
    logic [1:0] aop;
    logic       mr, mw, rw, br, jp;
    logic [1:0] wb;
    logic [2:0] kind;
  } ctl_t;

  slot_t dut_s, nb_s;
  assign dut_s = {id_pc_o, id_rs1_o, id_rs2_o, id_rs1_addr_o, id_rs2_addr_o, id_rd_o, id_imm_o, id_funct3_o,
                  id_funct7b5_o, id_alu_src_o, id_alu_op_o, id_mem_read_o, id_mem_write_o, id_reg_write_o,
                  id_is_branch_o, id_is_jump_o, id_wb_sel_o, id_illegal_o};
  assign nb_s  = {n_pc, n_rs1, n_rs2, n_a1, n_a2, n_rd, n_imm, n_f3, n_f7, n_src, n_aop, n_mr, n_mw, n_rw,
                  n_br, n_jp, n_wb, n_ill};

  int n_chk, n_err;
  logic chk_en;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_slot(input string nm, input slot_t act, input slot_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: opcode table -> {legal, uses rs1, uses rs2, src, aop, mr, mw, rw, br, jp, wb, imm kind}
  function automatic ctl_t ctl_of(input logic [6:0] op);
    case (op)
      7'h33:   return {4'b1110, 2'b10, 5'b00100, 2'b00, 3'd0};
      7'h13:   return {4'b1101, 2'b10, 5'b00100, 2'b00, 3'd1};
      7'h03:   return {4'b1101, 2'b00, 5'b10100, 2'b01, 3'd1};
      7'h23:   return {4'b1111, 2'b00, 5'b01000, 2'b00, 3'd2};
      7'h63:   return {4'b1110, 2'b01, 5'b00010, 2'b00, 3'd3};
      7'h6F:   return {4'b1000, 2'b00, 5'b00101, 2'b10, 3'd5};
      7'h67:   return {4'b1101, 2'b00, 5'b00101, 2'b10, 3'd1};
      7'h37:   return {4'b1001, 2'b11, 5'b00100, 2'b00, 3'd4};
      7'h17:   return {4'b1001, 2'b00, 5'b00100, 2'b00, 3'd4};
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] inst, input logic [2:0] kind);
    int si;
    si = int'(inst);
    case (kind)
      3'd1:    return si >>> 20;
      3'd2:    return ((si >>> 25) <<< 5) | int'(inst[11:7]);
      3'd3:    return ((si >>> 31) <<< 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
      3'd4:    return si & 32'hFFFF_F000;
      3'd5:    return ((si >>> 31) <<< 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] m_rf [32];
  logic        m_valid;
  slot_t       m_s;
  logic [31:0] m_nb1, m_nb2;

  function automatic logic [31:0] read_op(input logic [4:0] a, input logic byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wb_we_i && (wb_addr_i == a)) return wb_data_i;
    return m_rf[a];
  endfunction

  function automatic logic wb_hit(input logic [4:0] a);
    return wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == a);
  endfunction

  function automatic logic exp_haz();
    ctl_t c;
    c = ctl_of(if_inst_i[6:0]);
    return if_valid_i && ex_ld_valid_i && (ex_ld_rd_i != 5'd0) &&
           ((c.u1 && (if_inst_i[19:15] == ex_ld_rd_i)) || (c.u2 && (if_inst_i[24:20] == ex_ld_rd_i)));
  endfunction

  function automatic logic exp_free();
    return !m_valid || id_ready_i;
  endfunction

  function automatic logic exp_ready();
    return flush_i || (exp_free() && !exp_haz());
  endfunction

  function automatic slot_t build();
    slot_t s;
    ctl_t  c;
    c     = ctl_of(if_inst_i[6:0]);
    s.pc  = if_pc_i;
    s.a1  = if_inst_i[19:15];
    s.a2  = if_inst_i[24:20];
    s.rd  = if_inst_i[11:7];
    s.rs1 = read_op(s.a1, 1'b1);
    s.rs2 = read_op(s.a2, 1'b1);
    s.imm = c.legal ? imm_of(if_inst_i, c.kind) : 32'd0;
    s.f3  = if_inst_i[14:12];
    s.f7  = if_inst_i[30];
    s.src = c.src; s.aop = c.aop; s.mr = c.mr; s.mw = c.mw; s.rw = c.rw;
    s.br  = c.br;  s.jp  = c.jp;  s.wb = c.wb; s.ill = !c.legal;
    return s;
  endfunction

  function automatic slot_t nb_exp();
    slot_t s;
    s = m_s;
    s.rs1 = m_nb1;
    s.rs2 = m_nb2;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      m_valid <= 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
    end else begin
      if (flush_i) begin
        m_valid <= 1'b0;
      end else if (exp_free()) begin
        m_valid <= if_valid_i && !exp_haz();
        if (if_valid_i && !exp_haz()) begin
          m_s   <= build();
          m_nb1 <= read_op(if_inst_i[19:15], 1'b0);
          m_nb2 <= read_op(if_inst_i[24:20], 1'b0);
        end
      end else begin
        if (wb_hit(m_s.a1)) begin m_s.rs1 <= wb_data_i; m_nb1 <= wb_data_i; end
        if (wb_hit(m_s.a2)) begin m_s.rs2 <= wb_data_i; m_nb2 <= wb_data_i; end
      end
      if (wb_we_i && (wb_addr_i != 5'd0)) m_rf[wb_addr_i] <= wb_data_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk32("if_ready", 32'(if_ready_o), 32'(exp_ready()));
      chk32("nb_if_ready", 32'(n_if_ready), 32'(exp_ready()));
      chk32("id_valid", 32'(id_valid_o), 32'(m_valid));
      chk32("nb_id_valid", 32'(n_valid), 32'(m_valid));
      if (m_valid) begin
        chk_slot("slot", dut_s, m_s);
        chk_slot("nb_slot", nb_s, nb_exp());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_i = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; id_ready_i = 1'b1;
    if_pc_i = 32'd0; if_inst_i = 32'd0; wb_we_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0;
    ex_ld_valid_i = 1'b0; ex_ld_rd_i = 5'd0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst);
    if_valid_i = 1'b1; if_pc_i = pc; if_inst_i = inst;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we_i = we; wb_addr_i = a; wb_data_i = d;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;  9: w[6:0] = 7'h7F;  default: w[6:0] = 7'h0B;
    endcase
    return w;
  endfunction

  initial begin
    n_chk = 0; n_err = 0; chk_en = 1'b0;
    idle();
    rst_i = 1'b1;
    cyc(); cyc();
    chk_en = 1'b1;
    chk_slot("reset_slot", dut_s, '0);
    chk32("reset_valid", 32'(id_valid_o), 32'd0);
    rst_i = 1'b0;

    wb(1'b1, 5'd5, 32'h1234); cyc(); wb(1'b0, 5'd0, 32'd0);
    present(32'h100, 32'h0002_80B3); cyc();
    chk32("t1_valid", 32'(id_valid_o), 32'd1);
    chk32("t1_rs1", id_rs1_o, 32'h1234);
    chk32("t1_alu_op", 32'(id_alu_op_o), 32'd2);
    chk32("t1_reg_write", 32'(id_reg_write_o), 32'd1);
    chk32("t1_rd", 32'(id_rd_o), 32'd1);
    chk32("t1_model_rs1", m_s.rs1, 32'h1234);

    wb(1'b1, 5'd7, 32'hCAFE); present(32'h104, 32'h0003_8113); cyc(); wb(1'b0, 5'd0, 32'd0);
    chk32("t2_bypass_rs1", id_rs1_o, 32'hCAFE);
    chk32("t2_nobypass_rs1", n_rs1, 32'h0);

    ex_ld_valid_i = 1'b1; ex_ld_rd_i = 5'd3; present(32'h108, 32'h0021_8233); #1;
    chk32("t3_ready_stall", 32'(if_ready_o), 32'd0);
    cyc();
    chk32("t3_bubble", 32'(id_valid_o), 32'd0);
    ex_ld_valid_i = 1'b0; #1;
    chk32("t3_ready_go", 32'(if_ready_o), 32'd1);
    cyc();
    chk32("t3_accept", 32'(id_valid_o), 32'd1);
    chk32("t3_rd", 32'(id_rd_o), 32'd4);

    present(32'h200, 32'h0003_0413); cyc();
    chk32("t4_rs1_before", id_rs1_o, 32'h0);
    if_valid_i = 1'b0; id_ready_i = 1'b0; wb(1'b1, 5'd6, 32'hBEEF); cyc(); wb(1'b0, 5'd0, 32'd0);
    chk32("t4_rs1_refresh", id_rs1_o, 32'hBEEF);
    chk32("t4_nb_rs1_refresh", n_rs1, 32'hBEEF);
    chk32("t4_pc_held", id_pc_o, 32'h200);
    chk32("t4_rd_held", 32'(id_rd_o), 32'd8);
    chk32("t4_valid_held", 32'(id_valid_o), 32'd1);
    id_ready_i = 1'b1; cyc();
    chk32("t4_drain", 32'(id_valid_o), 32'd0);

    present(32'h300, 32'hFE00_0EE3); cyc();
    chk32("t5_b_imm", id_imm_o, 32'hFFFF_FFFC);
    chk32("t5_b_branch", 32'(id_is_branch_o), 32'd1);
    chk32("t5_b_alu_op", 32'(id_alu_op_o), 32'd1);
    chk32("t5_model_b_imm", m_s.imm, 32'hFFFF_FFFC);
    present(32'h304, 32'hABCD_E0B7); cyc();
    chk32("t5_u_imm", id_imm_o, 32'hABCD_E000);
    chk32("t5_u_alu_op", 32'(id_alu_op_o), 32'd3);
    chk32("t5_model_u_imm", m_s.imm, 32'hABCD_E000);

    id_ready_i = 1'b0; present(32'h400, 32'h0003_0413); flush_i = 1'b1; #1;
    chk32("t6_flush_ready", 32'(if_ready_o), 32'd1);
    cyc();
    chk32("t6_flush_valid", 32'(id_valid_o), 32'd0);
    flush_i = 1'b0; id_ready_i = 1'b1; present(32'h404, 32'h0000_007F); cyc();
    chk32("t6_ill_valid", 32'(id_valid_o), 32'd1);
    chk32("t6_illegal", 32'(id_illegal_o), 32'd1);
    chk32("t6_ill_ctrl", 32'({id_alu_src_o, id_alu_op_o, id_mem_read_o, id_mem_write_o, id_reg_write_o,
                              id_is_branch_o, id_is_jump_o, id_wb_sel_o}), 32'd0);
    chk32("t6_ill_imm", id_imm_o, 32'd0);
    present(32'h408, 32'h0002_80B3); cyc();
    rst_i = 1'b1; wb(1'b1, 5'd2, 32'h5555); cyc(); rst_i = 1'b0; wb(1'b0, 5'd0, 32'd0);
    chk_slot("t6_rst_slot", dut_s, '0);
    chk32("t6_rst_valid", 32'(id_valid_o), 32'd0);
    present(32'h40C, 32'h0002_80B3); cyc();
    chk32("t6_rf_cleared", id_rs1_o, 32'd0);

    for (int k = 0; k < 3000; k++) begin
      rst_i         = ($urandom_range(0, 499) == 0);
      flush_i       = ($urandom_range(0, 15) == 0);
      if_valid_i    = ($urandom_range(0, 9) < 8);
      id_ready_i    = ($urandom_range(0, 9) < 7);
      if_pc_i       = $urandom;
      if_inst_i     = rand_inst();
      wb_we_i       = ($urandom_range(0, 1) == 1);
      wb_addr_i     = 5'($urandom_range(0, 7));
      wb_data_i     = $urandom;
      ex_ld_valid_i = ($urandom_range(0, 2) == 0);
      ex_ld_rd_i    = 5'($urandom_range(0, 7));
      cyc();
    end

    idle(); cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the in-order RV32I/RV64I pipeline; sits between fetch and execute.
- Contains the register file with write-back bypass, the control decoder, the immediate generator and a load-use hazard detector.
- All results leave through a registered valid/ready output slot.
- Adds to the previous decode stage: handshaking, stall/flush, an illegal-opcode flag and operand refresh while the output is stalled.

Parameters:
- XLEN, 32, datapath/register width; legal values 32 or 64. Immediates sign-extend to XLEN.
- REG_ADDR_W, 5, register address width; the file holds 2**REG_ADDR_W entries.
- BYPASS_EN, 1, 1 = same-cycle write-back data forwarded into decode reads; 0 = read the array only.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  kill the in-flight instruction (branch/jump redirect)
- if_valid_i  in  1  fetch presents an instruction
- if_ready_o  out  1  decode accepts the instruction this cycle
- if_pc_i  in  XLEN  PC of the presented instruction
- if_inst_i  in  32  instruction word
- wb_we_i  in  1  write-back enable
- wb_addr_i  in  REG_ADDR_W  write-back destination
- wb_data_i  in  XLEN  write-back data
- ex_ld_valid_i  in  1  a load currently occupies EX
- ex_ld_rd_i  in  REG_ADDR_W  destination of that load
- id_valid_o  out  1  output slot holds a valid instruction
- id_ready_i  in  1  EX accepts the output slot
- id_pc_o  out  XLEN  PC
- id_rs1_o, id_rs2_o  out  XLEN  operand values
- id_rs1_addr_o, id_rs2_addr_o, id_rd_o  out  REG_ADDR_W  register indices
- id_imm_o  out  XLEN  sign-extended immediate
- id_funct3_o  out  3  inst[14:12]
- id_funct7b5_o  out  1  inst[30]
- id_alu_src_o  out  1  0 = rs2, 1 = immediate
- id_alu_op_o  out  2  00 ADD, 01 SUB, 10 FROM_FUNCT, 11 PASS_B
- id_mem_read_o, id_mem_write_o, id_reg_write_o, id_is_branch_o, id_is_jump_o  out  1 each  control flags
- id_wb_sel_o  out  2  00 ALU, 01 MEM, 10 PC4
- id_illegal_o  out  1  unrecognised opcode

Behaviour:
- Reset: sampled on the clock edge. All outputs registered except if_ready_o; every registered output resets to 0, including id_valid_o. Every register-file entry resets to 0.
- Register file:
  - 2 combinational read ports; write on the clock edge when wb_we_i is high and wb_addr_i != 0.
  - Entry x0 always reads 0.
  - With BYPASS_EN=1, a read whose index equals wb_addr_i (nonzero, wb_we_i high) returns wb_data_i.
- Source usage:
  - rs1 is used by OP, OP_IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by OP, STORE and BRANCH.
- Hazard: asserted when if_valid_i, ex_ld_valid_i and ex_ld_rd_i != 0 are all high, and a used rs1 or rs2 index equals ex_ld_rd_i.
- Slot-free condition: the output slot is free when id_valid_o is low or id_ready_i is high.
- if_ready_o = flush_i, or (slot free and no hazard).
- Next-state priority for the output slot:
  1. flush_i: id_valid_o <= 0. The input is consumed and discarded, and the held slot is discarded.
  2. Slot free and if_valid_i and no hazard: capture decoded fields and operands; id_valid_o <= 1.
  3. Slot free otherwise (hazard or no input): insert a bubble; id_valid_o <= 0.
  4. Held (id_valid_o high, id_ready_i low): payload stays stable. Exception: if wb_we_i is high and wb_addr_i (nonzero) equals id_rs1_addr_o or id_rs2_addr_o, the matching operand is replaced by wb_data_i.
- Latency: 1 cycle from input handshake to id_valid_o. Throughput is 1 per cycle with no stalls.
- Decode (opcode inst[6:0]); every flag not listed is 0, and alu_op/wb_sel default to 00:
  - OP 0110011: reg_write; alu_op 10.
  - OP_IMM 0010011: reg_write; alu_src; alu_op 10; I-type immediate.
  - LOAD 0000011: reg_write; alu_src; mem_read; wb_sel 01; I-type immediate.
  - STORE 0100011: alu_src; mem_write; S-type immediate.
  - BRANCH 1100011: is_branch; alu_op 01; B-type immediate.
  - JAL 1101111: reg_write; is_jump; wb_sel 10; J-type immediate.
  - JALR 1100111: reg_write; alu_src; is_jump; wb_sel 10; I-type immediate.
  - LUI 0110111: reg_write; alu_src; alu_op 11; U-type immediate.
  - AUIPC 0010111: reg_write; alu_src; U-type immediate.
  - Any other opcode: id_illegal_o = 1, all enables 0, immediate 0. It is still passed downstream with id_valid_o = 1.
- Immediates: RV32I I/S/B/U/J bit placement. B and J have bit 0 = 0. U = inst[31:12] << 12. All sign-extend from inst[31] to XLEN.
- Simultaneous flush_i and hazard: flush wins; if_ready_o = 1.

Test Plan:
1. Reset, then write x5 = 0x1234 via WB; next cycle present add x1,x5,x0 (0x000280B3) -> one cycle later id_valid_o=1, id_rs1_o=0x1234, id_alu_op_o=10, id_reg_write_o=1, id_rd_o=1.
2. Same cycle: wb_we_i, x7 = 0xCAFE, and present an instruction reading x7 -> with BYPASS_EN=1, id_rs1_o=0xCAFE; with BYPASS_EN=0, id_rs1_o=0 (prior value).
3. ex_ld_valid_i=1, ex_ld_rd_i=3; present add x4,x3,x2 -> if_ready_o=0 and a bubble is inserted (id_valid_o=0). Drop ex_ld_valid_i -> accepted the next cycle.
4. Hold id_ready_i=0 with a slot reading x6; WB writes x6 = 0xBEEF -> id_rs1_o updates to 0xBEEF; all other fields unchanged.
5. Immediates: beq with imm -4 (0xFE000EE3) -> id_imm_o=0xFFFFFFFC, id_is_branch_o=1, id_alu_op_o=01. lui 0xABCDE000 -> id_imm_o=0xABCDE000, id_alu_op_o=11.
6. flush_i with a valid slot held and input present -> next cycle id_valid_o=0, input consumed. Opcode 0x7F -> id_illegal_o=1, all enables 0. rst_i mid-stream -> all outputs 0 the next cycle.
